memoria_dados_param: RTL
========================

# memoria_dados_param

Parametrised single-port data memory for the Redux-V datapath: configurable word width and depth, per-byte write enables, a request/ready handshake and a registered read with a valid strobe. Sits between the execute stage and the load/store path. The previous 8-bit × 256 data memory had no handshake and no defined initial contents. With the optional clear feature, this block zeroes every word after reset before accepting any access.

## Interface
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8, any other value is an elaboration error
- ADDR_WIDTH, 8, address width; depth DEPTH = 2^ADDR_WIDTH words
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  1  access request; accepted when req && pronto at a rising edge
- writeEnable  input  1  1 = write access, 0 = read access
- byteEnable  input  DATA_WIDTH/8  per-byte write mask; bit i covers dadoEntrada[8i+7:8i]; ignored on reads
- endereco  input  ADDR_WIDTH  word address
- dadoEntrada  input  DATA_WIDTH  write data
- pronto  output  1  block accepts requests
- dadoSaida  output  DATA_WIDTH  read data, registered
- saidaValida  output  1  dadoSaida updated by the access accepted on the previous edge

## Operation
- Two states: LIMPANDO (clear sweep) and OCIOSO (serving requests).
- Reset values:
  - With the clear feature: state = LIMPANDO, sweep counter = 0, pronto = 0, dadoSaida = 0, saidaValida = 0.
  - Without it: state = OCIOSO, pronto = 1, other outputs as above.
- LIMPANDO:
  - Each edge writes 0 to memory[counter] and increments counter.
  - On the edge that clears address DEPTH-1: state goes to OCIOSO and pronto is set to 1.
  - req is ignored: no write, saidaValida stays 0.
- OCIOSO, accepted write:
  - Bytes with byteEnable[i]=1 are updated at that edge; the others are unchanged.
  - The resulting merged word is driven on dadoSaida (write-first) with saidaValida = 1.
  - byteEnable all zero: memory unchanged, current word still returned.
- OCIOSO, accepted read: dadoSaida = memory[endereco], saidaValida = 1.
- No accepted request at an edge: saidaValida = 0 and dadoSaida holds its last value.
- Addresses cover the full DEPTH range, so there is no out-of-range case. The sweep counter never wraps past DEPTH-1.
- rst_n asserted at any time, including mid-sweep or mid-access:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - The sweep restarts from address 0.
  - Memory words not yet re-cleared keep their old contents until the sweep reaches them.

## Timing
- Read and write latency is 1 cycle: request sampled at edge N, dadoSaida/saidaValida valid after edge N.
- Throughput is one access per cycle. Back-to-back accesses give saidaValida high on consecutive cycles.
- Read after write to the same address on the next cycle returns the new data.
- pronto rises exactly DEPTH edges after rst_n deassertion (clear feature compiled in). pronto never falls except on reset.

## Configuration
- MEMORIA_DADOS_CLEAR_ON_RESET_EN defined:
  - LIMPANDO state and sweep counter exist.
  - All words read 0 after the sweep.
  - pronto is low for DEPTH cycles after reset.
- Not defined:
  - No sweep; pronto = 1 from reset.
  - Memory contents after power-up are undefined (X in simulation). Reset does not alter contents.

## Test plan
- Macro on, DATA_WIDTH=32, ADDR_WIDTH=8, release rst_n -> pronto = 0 for 256 edges, 1 after; read 0xA5 -> dadoSaida = 0, saidaValida high exactly one cycle.
- Write 0xDEADBEEF, byteEnable = 4'b1111, address 3 -> dadoSaida = 0xDEADBEEF after the write edge; read of 3 on the next cycle -> 0xDEADBEEF.
- Write 0x11223344, byteEnable = 4'b0101, over 0xDEADBEEF at address 3 -> dadoSaida = 0xDE22BE44; subsequent read of 3 -> 0xDE22BE44.
- Write 0xFFFFFFFF to 0x10 while pronto = 0 -> saidaValida stays 0; after pronto, read of 0x10 -> 0.
- Assert rst_n low at sweep edge 100, release -> outputs 0 immediately; pronto rises 256 edges after release.
- Macro off: pronto = 1 at reset. Reads of 1, 2, 3 on consecutive cycles, after writing 0xA, 0xB, 0xC there -> saidaValida high 3 consecutive cycles with data 0xA, 0xB, 0xC.

Source files
------------

// File: rtl/memoria_dados_param.sv
`default_nettype none
// ============================================================================
// memoria_dados_param : single-port data memory, per-byte write enables,
// req/pronto handshake, registered write-first read with valid strobe.
// Optional zeroing sweep after reset: define MEMORIA_DADOS_CLEAR_ON_RESET_EN.
// Rev 1.0
// ============================================================================
module memoria_dados_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic                      writeEnable,
    input  logic [DATA_WIDTH/8-1:0]   byteEnable,
    input  logic [ADDR_WIDTH-1:0]     endereco,
    input  logic [DATA_WIDTH-1:0]     dadoEntrada,
    output logic                      pronto,
    output logic [DATA_WIDTH-1:0]     dadoSaida,
    output logic                      saidaValida
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_width_check
            $error("memoria_dados_param: DATA_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_pronto;
    logic                  w_limpando;
    logic [ADDR_WIDTH-1:0] w_end_limpeza;
    logic                  w_aceito;
    logic [DATA_WIDTH-1:0] w_lida;
    logic [DATA_WIDTH-1:0] w_mesclado;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

`ifdef MEMORIA_DADOS_CLEAR_ON_RESET_EN
    typedef enum logic [0:0] {
        LIMPANDO = 1'b0,
        OCIOSO   = 1'b1
    } estado_t;

    estado_t               r_estado;
    estado_t               w_estado_prox;
    logic [ADDR_WIDTH-1:0] r_contador;
    logic [ADDR_WIDTH-1:0] w_contador_prox;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado   <= LIMPANDO;
            r_contador <= '0;
        end else begin
            r_estado   <= w_estado_prox;
            r_contador <= w_contador_prox;
        end
    end

    // Counter parks on the last address instead of wrapping.
    always_comb begin
        w_estado_prox   = r_estado;
        w_contador_prox = r_contador;
        w_limpando      = 1'b0;
        if (r_estado == LIMPANDO) begin
            w_limpando = 1'b1;
            if (r_contador == '1) begin
                w_estado_prox = OCIOSO;
            end else begin
                w_contador_prox = r_contador + ADDR_WIDTH'(1);
            end
        end
    end

    assign w_pronto      = (r_estado == OCIOSO);
    assign w_end_limpeza = r_contador;
`else
    assign w_pronto      = 1'b1;
    assign w_limpando    = 1'b0;
    assign w_end_limpeza = '0;
`endif

    assign pronto   = w_pronto;
    assign w_aceito = req && w_pronto;
    assign w_lida   = r_mem[endereco];

    generate
        for (genvar i = 0; i < NBYTES; i++) begin : g_byte
            assign w_mesclado[8*i +: 8] = byteEnable[i] ? dadoEntrada[8*i +: 8]
                                                        : w_lida[8*i +: 8];
        end
    endgenerate

    // Memory is never written while reset is held, so untouched words survive it.
    assign w_mem_we    = rst_n && (w_limpando || (w_aceito && writeEnable));
    assign w_mem_addr  = w_limpando ? w_end_limpeza : endereco;
    assign w_mem_wdata = w_limpando ? '0 : w_mesclado;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dadoSaida   <= '0;
            saidaValida <= 1'b0;
        end else begin
            saidaValida <= w_aceito;
            if (w_aceito) begin
                dadoSaida <= writeEnable ? w_mesclado : w_lida;
            end
        end
    end

endmodule
`default_nettype wire
